// File: rtl/fma_seq_ctrl_pkg.sv
// FMA sequencer shared types: float field layout, operand classes, FSM states.
// Latency: n/a (types, constants and a pure classification function).
// Backpressure: n/a.
package fma_seq_ctrl_pkg;

  localparam int SIGN_W = 1;
  localparam int EXP_W  = 8;
  localparam int MANT_W = 23;
  localparam int FP_W   = SIGN_W + EXP_W + MANT_W;

  localparam logic [EXP_W-1:0] EXP_MAX = 8'hFF;
  localparam logic [FP_W-1:0]  QNAN    = 32'h7FC0_0000;

  typedef struct packed {
    logic [SIGN_W-1:0] sign;
    logic [EXP_W-1:0]  exp;
    logic [MANT_W-1:0] mant;
  } fp_t;

  typedef struct packed {
    logic nan;
    logic inf;
    logic zero;
  } cls_t;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CHECK = 3'd1,
    S_MUL   = 3'd2,
    S_ALIGN = 3'd3,
    S_ADD   = 3'd4,
    S_NORM  = 3'd5,
    S_ROUND = 3'd6,
    S_DONE  = 3'd7
  } state_t;

  // Denormals classify as zero: the datapath always inserts the hidden 1.
  function automatic cls_t classify(fp_t f);
    cls_t c;
    c.nan  = (f.exp == EXP_MAX) && (f.mant != '0);
    c.inf  = (f.exp == EXP_MAX) && (f.mant == '0);
    c.zero = (f.exp == '0);
    return c;
  endfunction

endpackage

// File: rtl/fma_seq_ctrl_if.sv
// Operand-in / result-out handshake bundle for the FMA sequencer.
// Latency: n/a (wiring only).
// Backpressure: valid/ready on both directions.
interface fma_seq_ctrl_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] data_A;
  logic [31:0] data_B;
  logic [31:0] data_C;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic        out_special;

  modport slave (
    input  in_valid, data_A, data_B, data_C, out_ready,
    output in_ready, out_valid, out_result, out_special
  );

  modport master (
    output in_valid, data_A, data_B, data_C, out_ready,
    input  in_ready, out_valid, out_result, out_special
  );
endinterface

// File: rtl/fma_seq_ctrl_special_chk.sv
// Screens an A*B+C triple for NaN/Inf/zero-product cases and forms the bypass result.
// Latency: combinational.
// Backpressure: none.
module fma_seq_ctrl_special_chk
  import fma_seq_ctrl_pkg::*;
(
  input  fp_t             a,
  input  fp_t             b,
  input  fp_t             c,
  output logic            is_special,
  output logic [FP_W-1:0] result
);

  cls_t              ca, cb, cc;
  logic [SIGN_W-1:0] sp;
  logic              prod_inf, prod_zero, inf_x_zero, any_nan;

  // Classify operands and pick the bypass result in priority order.
  always_comb begin
    ca         = classify(a);
    cb         = classify(b);
    cc         = classify(c);
    sp         = a.sign ^ b.sign;
    any_nan    = ca.nan | cb.nan | cc.nan;
    prod_inf   = ca.inf | cb.inf;
    prod_zero  = ca.zero | cb.zero;
    inf_x_zero = (ca.inf & cb.zero) | (cb.inf & ca.zero);
    // A zero/denormal C on its own still goes through the datapath.
    is_special = any_nan | prod_inf | cc.inf | prod_zero;
    result     = '0;
    if (any_nan || inf_x_zero || (prod_inf && cc.inf && (c.sign != sp)))
      result = QNAN;
    else if (prod_inf)
      result = {sp, EXP_MAX, {MANT_W{1'b0}}};
    else if (cc.inf)
      result = c;
    else if (!cc.zero)
      result = c;
    else
      result = {sp & c.sign, {(FP_W-SIGN_W){1'b0}}};
  end

endmodule

// File: rtl/fma_seq_ctrl.sv
// Sequences the shared FMA datapath MUL->ALIGN->ADD->NORM->ROUND for one op at a time.
// Latency: accept -> out_valid 4+MUL_LAT+ADD_LAT cycles; special operands 1 cycle.
// Backpressure: in_ready only in IDLE or when the DONE result is taken that cycle.
module fma_seq_ctrl
  import fma_seq_ctrl_pkg::*;
#(
  parameter int MUL_LAT = 2,  // multiplier latency, must be >= 1
  parameter int ADD_LAT = 1   // adder latency, must be >= 1
) (
  input  logic             clk,
  input  logic             rst_n,
  fma_seq_ctrl_if.slave    bus,
  output logic [FP_W-1:0]  dp_A,
  output logic [FP_W-1:0]  dp_B,
  output logic [FP_W-1:0]  dp_C,
  output logic             en_mul,
  output logic             en_align,
  output logic             en_add,
  output logic             en_norm,
  output logic             en_round,
  input  logic [FP_W-1:0]  dp_result,
  output logic             busy
);

  localparam int CW = 8;

  state_t            state;
  logic [CW-1:0]     cnt;
  logic              out_valid_q;
  logic              out_special_q;
  logic [FP_W-1:0]   out_result_q;
  logic              in_ready;
  logic              accept;
  logic              spec_hit;
  logic [FP_W-1:0]   spec_res;

  fma_seq_ctrl_special_chk u_special_chk (
    .a          (fp_t'(dp_A)),
    .b          (fp_t'(dp_B)),
    .c          (fp_t'(dp_C)),
    .is_special (spec_hit),
    .result     (spec_res)
  );

  assign in_ready        = (state == S_IDLE) || ((state == S_DONE) && bus.out_ready);
  assign accept          = bus.in_valid && in_ready;
  assign busy            = (state != S_IDLE);
  assign bus.in_ready    = in_ready;
  assign bus.out_valid   = out_valid_q;
  assign bus.out_result  = out_result_q;
  assign bus.out_special = out_special_q;

  // Controller FSM; stage enables and result are registered alongside the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      cnt           <= '0;
      dp_A          <= '0;
      dp_B          <= '0;
      dp_C          <= '0;
      en_mul        <= 1'b0;
      en_align      <= 1'b0;
      en_add        <= 1'b0;
      en_norm       <= 1'b0;
      en_round      <= 1'b0;
      out_valid_q   <= 1'b0;
      out_special_q <= 1'b0;
      out_result_q  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            dp_A  <= bus.data_A;
            dp_B  <= bus.data_B;
            dp_C  <= bus.data_C;
            state <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (spec_hit) begin
            out_result_q  <= spec_res;
            out_special_q <= 1'b1;
            out_valid_q   <= 1'b1;
            state         <= S_DONE;
          end else begin
            en_mul <= 1'b1;
            cnt    <= CW'(MUL_LAT - 1);
            state  <= S_MUL;
          end
        end
        S_MUL: begin
          if (cnt == '0) begin
            en_mul   <= 1'b0;
            en_align <= 1'b1;
            state    <= S_ALIGN;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_ALIGN: begin
          en_align <= 1'b0;
          en_add   <= 1'b1;
          cnt      <= CW'(ADD_LAT - 1);
          state    <= S_ADD;
        end
        S_ADD: begin
          if (cnt == '0) begin
            en_add  <= 1'b0;
            en_norm <= 1'b1;
            state   <= S_NORM;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_NORM: begin
          en_norm  <= 1'b0;
          en_round <= 1'b1;
          state    <= S_ROUND;
        end
        S_ROUND: begin
          en_round      <= 1'b0;
          out_result_q  <= dp_result;
          out_special_q <= 1'b0;
          out_valid_q   <= 1'b1;
          state         <= S_DONE;
        end
        S_DONE: begin
          if (bus.out_ready) begin
            out_valid_q   <= 1'b0;
            out_special_q <= 1'b0;
            if (accept) begin
              // Back-to-back: next operands land while the result leaves.
              dp_A  <= bus.data_A;
              dp_B  <= bus.data_B;
              dp_C  <= bus.data_C;
              state <= S_CHECK;
            end else begin
              state <= S_IDLE;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fma_seq_ctrl.sv
// Directed bench for fma_seq_ctrl: latency, enables, special bypass, backpressure, reset.
// Latency: n/a.
// Backpressure: exercised by holding out_ready low in DONE.
module tb_fma_seq_ctrl;

  localparam logic [31:0] DP_RES = 32'h4020_0000;
  localparam logic [31:0] QN     = 32'h7FC0_0000;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] c;
    logic [31:0] r;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [31:0] dp_A, dp_B, dp_C, dp_result;
  logic        en_mul, en_align, en_add, en_norm, en_round, busy;

  int n_pass  = 0;
  int n_total = 0;
  int seen_mul, seen_align, seen_add, seen_norm, seen_round, seen_multi;

  fma_seq_ctrl_if bus ();

  fma_seq_ctrl #(.MUL_LAT(2), .ADD_LAT(1)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .dp_A      (dp_A),
    .dp_B      (dp_B),
    .dp_C      (dp_C),
    .en_mul    (en_mul),
    .en_align  (en_align),
    .en_add    (en_add),
    .en_norm   (en_norm),
    .en_round  (en_round),
    .dp_result (dp_result),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout want finish");
    $fatal(1);
  end

  // Issue one triple from IDLE and wait for out_valid; lat = edges after the accept edge.
  task automatic run_op(input logic [31:0] a, b, c, output int lat);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.data_A   = a;
    bus.data_B   = b;
    bus.data_C   = c;
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.data_A   = 32'hDEAD_BEEF;
    bus.data_B   = 32'h1234_5678;
    bus.data_C   = 32'hCAFE_F00D;
    seen_mul = 0; seen_align = 0; seen_add = 0; seen_norm = 0; seen_round = 0; seen_multi = 0;
    lat = 0;
    while (!bus.out_valid && lat < 30) begin
      if (en_mul)   seen_mul++;
      if (en_align) seen_align++;
      if (en_add)   seen_add++;
      if (en_norm)  seen_norm++;
      if (en_round) seen_round++;
      if ($countones({en_mul, en_align, en_add, en_norm, en_round}) > 1) seen_multi++;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset();
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    bus.data_A    = '0;
    bus.data_B    = '0;
    bus.data_C    = '0;
    dp_result     = DP_RES;
    #1 rst_n = 1'b0;
    #11;
    n_total++; if (bus.in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); else n_pass++;
    n_total++; if (bus.out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); else n_pass++;
    n_total++; if ({en_mul, en_align, en_add, en_norm, en_round, busy} !== 6'b0)
      $display("FAIL reset_en_busy: got %b want 000000", {en_mul, en_align, en_add, en_norm, en_round, busy}); else n_pass++;
    n_total++; if ({dp_A, dp_B, dp_C, bus.out_result} !== 128'h0 || bus.out_special !== 1'b0)
      $display("FAIL reset_data: got %h/%b want 0/0", {dp_A, dp_B, dp_C, bus.out_result}, bus.out_special); else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_datapath(input logic [31:0] a, b, c, input string nm);
    int lat;
    run_op(a, b, c, lat);
    n_total++; if (lat !== 7) $display("FAIL %s_latency: got %0d want 7", nm, lat); else n_pass++;
    n_total++; if ({seen_mul, seen_align, seen_add, seen_norm, seen_round} !== {32'd2, 32'd1, 32'd1, 32'd1, 32'd1})
      $display("FAIL %s_enables: got mul=%0d align=%0d add=%0d norm=%0d round=%0d want 2,1,1,1,1",
               nm, seen_mul, seen_align, seen_add, seen_norm, seen_round); else n_pass++;
    n_total++; if (seen_multi !== 0) $display("FAIL %s_onehot: got %0d overlapping cycles want 0", nm, seen_multi); else n_pass++;
    n_total++; if (bus.out_result !== DP_RES || bus.out_special !== 1'b0)
      $display("FAIL %s_result: got %h/%b want %h/0", nm, bus.out_result, bus.out_special, DP_RES); else n_pass++;
    n_total++; if (dp_A !== a || dp_B !== b || dp_C !== c)
      $display("FAIL %s_operands: got %h %h %h want %h %h %h", nm, dp_A, dp_B, dp_C, a, b, c); else n_pass++;
    @(negedge clk);
    n_total++; if (bus.out_valid !== 1'b0 || busy !== 1'b0)
      $display("FAIL %s_drain: got valid=%b busy=%b want 0 0", nm, bus.out_valid, busy); else n_pass++;
  endtask

  task automatic test_special();
    int   lat;
    vec_t v [10] = '{
      '{32'h7FC0_0001, 32'h3F80_0000, 32'h3F80_0000, QN},
      '{32'h3F80_0000, 32'h7FA0_0000, 32'h3F80_0000, QN},
      '{32'h7F80_0000, 32'h0000_0000, 32'h3F80_0000, QN},
      '{32'h7F80_0000, 32'h3F80_0000, 32'hFF80_0000, QN},
      '{32'h7F80_0000, 32'hC000_0000, 32'h3F80_0000, 32'hFF80_0000},
      '{32'h7F80_0000, 32'h3F80_0000, 32'h7F80_0000, 32'h7F80_0000},
      '{32'h3F80_0000, 32'h3F80_0000, 32'hFF80_0000, 32'hFF80_0000},
      '{32'h0000_0000, 32'h4000_0000, 32'hBF80_0000, 32'hBF80_0000},
      '{32'h8000_0000, 32'h3F80_0000, 32'h8000_0000, 32'h8000_0000},
      '{32'h8000_0000, 32'h3F80_0000, 32'h0000_0000, 32'h0000_0000}
    };
    for (int i = 0; i < 10; i++) begin
      run_op(v[i].a, v[i].b, v[i].c, lat);
      n_total++; if (lat !== 1) $display("FAIL special%0d_latency: got %0d want 1", i, lat); else n_pass++;
      n_total++; if (bus.out_result !== v[i].r || bus.out_special !== 1'b1)
        $display("FAIL special%0d_result: got %h/%b want %h/1", i, bus.out_result, bus.out_special, v[i].r); else n_pass++;
      n_total++; if (seen_mul + seen_align + seen_add + seen_norm + seen_round !== 0)
        $display("FAIL special%0d_no_enables: got %0d enable cycles want 0", i,
                 seen_mul + seen_align + seen_add + seen_norm + seen_round); else n_pass++;
      @(negedge clk);
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    bus.out_ready = 1'b0;
    run_op(32'h3F80_0000, 32'h4000_0000, 32'h3F00_0000, lat);
    n_total++; if (lat !== 7) $display("FAIL bp_latency: got %0d want 7", lat); else n_pass++;
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = 1'b1;
      bus.data_A   = 32'h7FC0_0001;
      #1;
      n_total++; if (bus.out_valid !== 1'b1 || bus.out_result !== DP_RES || bus.in_ready !== 1'b0)
        $display("FAIL bp_hold%0d: got valid=%b res=%h in_ready=%b want 1 %h 0",
                 i, bus.out_valid, bus.out_result, bus.in_ready, DP_RES); else n_pass++;
      @(negedge clk);
    end
    n_total++; if (dp_A !== 32'h3F80_0000) $display("FAIL bp_ignored: got dp_A=%h want 3f800000", dp_A); else n_pass++;
    bus.out_ready = 1'b1;
    bus.data_A    = 32'h7FC0_0001;
    bus.data_B    = 32'h3F80_0000;
    bus.data_C    = 32'h3F80_0000;
    #1;
    n_total++; if (bus.in_ready !== 1'b1) $display("FAIL b2b_in_ready: got %b want 1", bus.in_ready); else n_pass++;
    @(negedge clk);
    bus.in_valid = 1'b0;
    n_total++; if (bus.out_valid !== 1'b0 || busy !== 1'b1 || dp_A !== 32'h7FC0_0001)
      $display("FAIL b2b_check: got valid=%b busy=%b dp_A=%h want 0 1 7fc00001", bus.out_valid, busy, dp_A); else n_pass++;
    @(negedge clk);
    n_total++; if (bus.out_valid !== 1'b1 || bus.out_result !== QN || bus.out_special !== 1'b1)
      $display("FAIL b2b_result: got %b %h %b want 1 7fc00000 1", bus.out_valid, bus.out_result, bus.out_special); else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_reset_mid_op();
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.data_A   = 32'h3F80_0000;
    bus.data_B   = 32'h4000_0000;
    bus.data_C   = 32'h3F00_0000;
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(negedge clk);
    n_total++; if (en_mul !== 1'b1) $display("FAIL rst_mid_in_mul: got en_mul=%b want 1", en_mul); else n_pass++;
    rst_n = 1'b0;
    #1;
    n_total++; if ({en_mul, en_align, en_add, en_norm, en_round} !== 5'b0 || bus.in_ready !== 1'b1 || busy !== 1'b0)
      $display("FAIL rst_mid_clear: got en=%b in_ready=%b busy=%b want 00000 1 0",
               {en_mul, en_align, en_add, en_norm, en_round}, bus.in_ready, busy); else n_pass++;
    n_total++; if (dp_A !== 32'h0 || bus.out_valid !== 1'b0)
      $display("FAIL rst_mid_data: got dp_A=%h valid=%b want 0 0", dp_A, bus.out_valid); else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    test_datapath(32'h3F80_0000, 32'h4000_0000, 32'h3F00_0000, "after_rst");
  endtask

  initial begin
    test_reset();
    test_datapath(32'h3F80_0000, 32'h4000_0000, 32'h3F00_0000, "fma_1x2p05");
    test_datapath(32'h3F80_0000, 32'h3F80_0000, 32'h0000_0000, "c_zero");
    test_datapath(32'h3F80_0000, 32'h3F80_0000, 32'h0000_0001, "c_denorm");
    test_special();
    test_back_to_back();
    test_reset_mid_op();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
